// File: rtl/jerk_pkg.sv
// Shared types, constants and helpers for the jerk counter stream monitor.
package jerk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] BASE_VAL   = 8'h01;
  localparam logic [7:0] FIRST_PEAK = 8'h02;
  localparam logic [7:0] LAST_PEAK  = 8'h80;
  localparam int         PERIOD     = 14;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

  function automatic logic [2:0] log2_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/jerk_expect.sv
// Next expected stream value: base after a peak, doubled peak after a base (wrapping 0x80 -> 0x02).
module jerk_expect
  import jerk_pkg::*;
(
  input  logic [7:0] i_peak,
  input  logic       i_expect_base,
  output logic [7:0] o_exp
);

  always_comb begin
    o_exp = BASE_VAL;
    if (i_expect_base) begin
      o_exp = (i_peak == LAST_PEAK) ? FIRST_PEAK : {i_peak[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/jerk_mon.sv
// Lock/track monitor for the period-14 jerk counter stream.
// Build option: define JERK_MON_RESYNC_EN to re-seed directly on a mismatching legal peak.
module jerk_mon
  import jerk_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       count_in,
  output logic             locked,
  output logic             err,
  output logic [2:0]       idx,
  output logic             sweep_done,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] LC = 4'(LOCK_CNT);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_match_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]       r_peak, w_peak_nxt, w_exp;
  logic             r_expect_base, w_base_nxt;
  logic             w_legal, w_is_peak, w_match, w_resync;
  logic             w_err_nxt, w_sweep_nxt;
  logic             r_locked, r_err, r_sweep;
  logic [2:0]       r_idx;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;

  jerk_expect u_expect (
    .i_peak        (r_peak),
    .i_expect_base (r_expect_base),
    .o_exp         (w_exp)
  );

  // Valid-only stream: count_in is consumed on every edge with in_valid=1; the source is never stalled.
  assign w_legal   = is_onehot(count_in);
  assign w_is_peak = w_legal && (count_in != BASE_VAL);
  assign w_match   = w_legal && (count_in == w_exp);
  assign w_cnt_inc = (r_match_cnt >= LC) ? LC : r_match_cnt + 4'd1;

`ifdef JERK_MON_RESYNC_EN
  assign w_resync = w_is_peak;
`else
  assign w_resync = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= HUNT;
      r_match_cnt   <= 4'd0;
      r_peak        <= 8'h00;
      r_expect_base <= 1'b0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_sweep       <= 1'b0;
      r_idx         <= 3'd0;
      r_err_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_match_cnt   <= w_cnt_nxt;
      r_peak        <= w_peak_nxt;
      r_expect_base <= w_base_nxt;
      r_locked      <= (w_state_nxt == LOCKED);
      r_err         <= w_err_nxt;
      r_sweep       <= w_sweep_nxt;
      r_idx         <= log2_idx(w_peak_nxt);
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_match_cnt;
    w_peak_nxt  = r_peak;
    w_base_nxt  = r_expect_base;
    if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (w_is_peak) begin
            w_state_nxt = ACQ;
            w_cnt_nxt   = 4'd1;
            w_peak_nxt  = count_in;
            w_base_nxt  = 1'b0;
          end
        end
        ACQ, LOCKED: begin
          if (w_match) begin
            if (count_in == BASE_VAL) begin
              w_base_nxt = 1'b1;
            end else begin
              w_peak_nxt = count_in;
              w_base_nxt = 1'b0;
            end
            if (r_state == ACQ) begin
              w_cnt_nxt = w_cnt_inc;
              if (w_cnt_inc == LC) w_state_nxt = LOCKED;
            end
          end else if (w_resync) begin
            w_state_nxt = ACQ;
            w_cnt_nxt   = 4'd1;
            w_peak_nxt  = count_in;
            w_base_nxt  = 1'b0;
          end else begin
            w_state_nxt = HUNT;
            w_cnt_nxt   = 4'd0;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // A mismatch outranks 0x80, so sweep_done requires a match.
  always_comb begin
    w_err_nxt     = in_valid && (r_state == LOCKED) && !w_match;
    w_sweep_nxt   = in_valid && (r_state == LOCKED) && w_match && (count_in == LAST_PEAK);
    w_err_cnt_nxt = r_err_cnt;
    if (w_err_nxt && (r_err_cnt != {ERR_W{1'b1}})) begin
      w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
    end
  end

  assign locked     = r_locked;
  assign err        = r_err;
  assign idx        = r_idx;
  assign sweep_done = r_sweep;
  assign err_cnt    = r_err_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_jerk_mon.sv
// Bench for jerk_mon: two widths of err_cnt driven in lockstep, checked against a stream-phase model.
module tb_jerk_mon;
  import jerk_pkg::*;

  localparam int LOCK_CNT = 4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] count_in;

  logic       locked8, err8, sweep8;
  logic [2:0] idx8;
  logic [7:0] err_cnt8;
  logic [1:0] state8;
  logic       locked2, err2, sweep2;
  logic [2:0] idx2;
  logic [1:0] err_cnt2;
  logic [1:0] state2;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 0;

  jerk_mon #(.LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .locked(locked8), .err(err8), .idx(idx8), .sweep_done(sweep8),
    .err_cnt(err_cnt8), .dbg_state(state8)
  );

  jerk_mon #(.LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .locked(locked2), .err(err2), .idx(idx2), .sweep_done(sweep2),
    .err_cnt(err_cnt2), .dbg_state(state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: mode 0=hunting, 1=acquiring, 2=locked; phase = position in the 14-long stream
  typedef struct {
    int   mode;
    int   phase;
    int   cnt;
    int   idx;
    int   e8;
    int   e2;
    logic err;
    logic sweep;
  } mstate_t;

  mstate_t m;

  function automatic logic [7:0] seq_at(input int i);
    return (i % 2 == 0) ? 8'h01 : 8'(1 << ((i + 1) / 2));
  endfunction

  function automatic mstate_t seed(input mstate_t s, input logic [7:0] v);
    mstate_t n = s;
    n.mode  = 1;
    n.phase = 2 * $clog2(v) - 1;
    n.idx   = $clog2(v);
    n.cnt   = 1;
    return n;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic ok, input logic [7:0] v);
    mstate_t n = s;
    bit legal, hit;
    int nxt;
    n.err   = 1'b0;
    n.sweep = 1'b0;
    if (!ok) return n;
    legal = ($countones(v) == 1);
    nxt   = (s.phase + 1) % PERIOD;
    hit   = legal && (v == seq_at(nxt));
    if (s.mode == 0) begin
      if (legal && v != 8'h01) n = seed(n, v);
    end else if (hit) begin
      n.phase = nxt;
      if (v != 8'h01) n.idx = $clog2(v);
      if (s.mode == 1) begin
        n.cnt = (s.cnt + 1 > LOCK_CNT) ? LOCK_CNT : s.cnt + 1;
        if (n.cnt == LOCK_CNT) n.mode = 2;
      end else if (v == 8'h80) begin
        n.sweep = 1'b1;
      end
    end else begin
      if (s.mode == 2) begin
        n.err = 1'b1;
        n.e8  = (s.e8 < 255) ? s.e8 + 1 : 255;
        n.e2  = (s.e2 < 3) ? s.e2 + 1 : 3;
      end
`ifdef JERK_MON_RESYNC_EN
      if (legal && v != 8'h01) n = seed(n, v);
      else begin
        n.mode = 0;
        n.cnt  = 0;
      end
`else
      n.mode = 0;
      n.cnt  = 0;
`endif
    end
    return n;
  endfunction

  function automatic logic [1:0] mode_state(input int mode);
    case (mode)
      1:       return ACQ;
      2:       return LOCKED;
      default: return HUNT;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '{default: 0};
    else        m <= model_step(m, in_valid, count_in);
  end

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("locked8", 32'(locked8), 32'(m.mode == 2));
      check("err8",    32'(err8),    32'(m.err));
      check("sweep8",  32'(sweep8),  32'(m.sweep));
      check("idx8",    32'(idx8),    32'(m.idx));
      check("errcnt8", 32'(err_cnt8), 32'(m.e8));
      check("state8",  32'(state8),  32'(mode_state(m.mode)));
      check("locked2", 32'(locked2), 32'(m.mode == 2));
      check("err2",    32'(err2),    32'(m.err));
      check("sweep2",  32'(sweep2),  32'(m.sweep));
      check("idx2",    32'(idx2),    32'(m.idx));
      check("errcnt2", 32'(err_cnt2), 32'(m.e2));
      check("state2",  32'(state2),  32'(mode_state(m.mode)));
    end
  end

  // drivers: inputs change on the falling edge; send returns at the next falling edge
  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    count_in = v;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    count_in = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic lock_2_1_4_1();
    send(8'h02); send(8'h01); send(8'h04); send(8'h01);
  endtask

  logic [1:0] exp_sat [5];

  initial begin
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset    = 1'b0;
    in_valid = 1'b0;
    count_in = 8'h00;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_locked", 32'(locked8), 0);
    check("rst_idx",    32'(idx8), 0);
    check("rst_errcnt", 32'(err_cnt8), 0);
    check("rst_state",  32'(state8), 32'(HUNT));
    reset = 1'b1;
    idle(1);

    // acquire lock on 2,1,4,1
    send(8'h02); send(8'h01); send(8'h04);
    check("acq_not_locked", 32'(locked8), 0);
    send(8'h01);
    check("lock_after_4", 32'(locked8), 1);
    check("idx_after_4",  32'(idx8), 2);
    send(8'h08);
    check("idx_8", 32'(idx8), 3);
    send(8'h03);
    check("bad_err",    32'(err8), 1);
    check("bad_errcnt", 32'(err_cnt8), 1);
    check("bad_locked", 32'(locked8), 0);
    check("bad_state",  32'(state8), 32'(HUNT));
    idle(1);
    check("err_one_cycle", 32'(err8), 0);

    // sweep through 0x80 and wrap to 0x02
    send(8'h10); send(8'h01); send(8'h20); send(8'h01);
    send(8'h40); send(8'h01); send(8'h80);
    check("sweep_pulse", 32'(sweep8), 1);
    check("sweep_idx",   32'(idx8), 7);
    send(8'h01);
    check("sweep_once", 32'(sweep8), 0);
    send(8'h02);
    check("wrap_idx",    32'(idx8), 1);
    check("wrap_locked", 32'(locked8), 1);
    idle(1);

    // illegal zero while locked, then lock with gaps between valid samples
    send(8'h00);
    check("zero_errcnt", 32'(err_cnt8), 2);
    send(8'h04); idle(3);
    send(8'h01); idle(3);
    send(8'h08); idle(3);
    check("gap_not_locked", 32'(locked8), 0);
    send(8'h01);
    check("gap_locked", 32'(locked8), 1);
    check("gap_errcnt", 32'(err_cnt8), 2);

    // asynchronous reset mid-cycle while locked
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_locked8", 32'(locked8), 0);
    check("arst_errcnt8", 32'(err_cnt8), 0);
    check("arst_idx8",    32'(idx8), 0);
    check("arst_errcnt2", 32'(err_cnt2), 0);
    check("arst_state2",  32'(state2), 32'(HUNT));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(1);

    // five lock/mismatch rounds: narrow counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      lock_2_1_4_1();
      send(8'h03);
      check("sat_errcnt2", 32'(err_cnt2), 32'(exp_sat[k]));
      check("sat_errcnt8", 32'(err_cnt8), 32'(k + 1));
    end
    idle(1);

    // 0x10 injected where 0x01 is expected
    lock_2_1_4_1();
    send(8'h08);
    send(8'h10);
    check("inj_err", 32'(err8), 1);
`ifdef JERK_MON_RESYNC_EN
    check("inj_state", 32'(state8), 32'(ACQ));
    send(8'h01); send(8'h20);
    check("resync_not_locked", 32'(locked8), 0);
    send(8'h01);
    check("resync_locked", 32'(locked8), 1);
    check("resync_idx",    32'(idx8), 5);
`else
    check("inj_state", 32'(state8), 32'(HUNT));
    send(8'h01); send(8'h20); send(8'h01);
    check("hunt_state",  32'(state8), 32'(ACQ));
    check("hunt_locked", 32'(locked8), 0);
`endif
    idle(2);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/jerk_mon.md
Name: jerk_mon

Overview:
Downstream monitor for the 8-bit jerk counter stream. The upstream stream repeats with period 14: 1,2,1,4,1,8,1,16,1,32,1,64,1,128.
- Checks every valid sample against the expected next value.
- Acquires and holds lock, then reports the current peak bit index, a sweep-complete pulse, and protocol errors with a saturating error count.
- Sits between the jerk counter and the status/debug logic.

Parameters:
LOCK_CNT, 4, consecutive matching samples (including the seed) required to enter LOCKED; legal range 2..15
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  single clock; all state is updated on its rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  count_in is sampled on a rising clk edge only when in_valid=1
count_in  input  8  jerk counter value
locked  output  1  high while in state LOCKED
err  output  1  one-cycle pulse on a mismatch while LOCKED
idx  output  3  bit index of the last accepted peak (1..7); 0 after reset
sweep_done  output  1  one-cycle pulse when 8'h80 is accepted while LOCKED
err_cnt  output  ERR_W  number of LOCKED mismatches, saturating at all-ones

Behaviour:
- reset=0 (asynchronous): state=HUNT, locked=0, err=0, sweep_done=0, idx=0, err_cnt=0, match_cnt=0, peak=8'h00, expect_base=0. Assertion mid-operation aborts immediately, whatever the state.
- All outputs are registered and reflect a sample one clock after it is taken. err and sweep_done are 0 in every cycle without a qualifying event.
- in_valid=0: no state change. err and sweep_done are low; all other outputs hold.
- Legal sample: exactly one bit set. Zero or multi-bit values are illegal and always count as a mismatch.
- Expected-value rule:
  - After an accepted peak p (p≠1), the expected value is 8'h01.
  - After an accepted 8'h01 following peak p, the expected value is p<<1, except p=8'h80, which expects 8'h02.
  - Bit 0 is never a peak.
- HUNT:
  - 8'h01 or an illegal sample: stay in HUNT.
  - Legal sample p≠1: seed peak=p, idx=log2(p), match_cnt=1, expect 8'h01, go to ACQ.
- ACQ:
  - Match: match_cnt+1 and update peak/idx on a peak. When match_cnt reaches LOCK_CNT, go to LOCKED with locked=1 on the following clock.
  - Mismatch: go to HUNT; no err pulse, err_cnt unchanged.
- LOCKED:
  - Match: update peak/idx. Accepting 8'h80 pulses sweep_done.
  - Mismatch: err=1 for one cycle, err_cnt increments (holds at all-ones), locked=0, go to HUNT (see Optional Feature).
- Simultaneous 8'h80 and mismatch cannot occur; a mismatch takes priority and sweep_done stays 0.
- match_cnt saturates at LOCK_CNT and is cleared on entry to HUNT.

Optional Feature:
Macro JERK_MON_RESYNC_EN.
- Defined: a LOCKED or ACQ mismatch whose sample is a legal peak p≠1 re-seeds directly: peak=p, match_cnt=1, go to ACQ. On a LOCKED mismatch, err and err_cnt still update as normal.
- Undefined: every mismatch goes to HUNT as specified above.

Decomposition:
- Package jerk_pkg holds:
  - the state enum (HUNT, ACQ, LOCKED)
  - BASE_VAL=8'h01, FIRST_PEAK=8'h02, LAST_PEAK=8'h80, PERIOD=14
  - the onehot-legal check and the log2 index function
- One sub-module, jerk_expect (combinational): inputs peak and expect_base; outputs the expected next value.

Test Plan:
- Reset, then clean stream 2,1,4,1 with in_valid=1 → locked=1 one clock after sample 4 (LOCK_CNT=4); idx=2 after sample 4.
- While locked, feed 8'h03 instead of 8'h01 → err high exactly one cycle, err_cnt=1, locked=0, state HUNT.
- Locked stream reaching 64,1,128,1,2 → sweep_done pulses once after 128 with idx=7; after the following 2, idx=1 and locked stays 1.
- Clean stream with in_valid=0 gaps of 3 cycles between samples → lock timing counts only valid samples; no err.
- ERR_W=2: five lock/mismatch cycles → err_cnt sequence 1,2,3,3,3.
- reset low while locked with err_cnt=2 → all outputs 0 immediately, without waiting for clk. With JERK_MON_RESYNC_EN: locked stream, inject 16 where 1 is expected → err pulse, state ACQ, relock after LOCK_CNT-1 further matches.
